// File: rtl/apb4_master_if.sv
// APB4 bus signals between the apb4_master and an APB4 completer.
// The master modport drives the request fields and select/enable; the slave modport returns ready, error and read data.
interface apb4_master_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   paddr_o;
  logic [2:0]              pprot_o;
  logic                    pwrite_o;
  logic [DATA_WIDTH-1:0]   pwdata_o;
  logic [DATA_WIDTH/8-1:0] pstrb_o;
  logic                    psel_o;
  logic                    penable_o;
  logic                    pready_i;
  logic                    pslverr_i;
  logic [DATA_WIDTH-1:0]   prdata_i;

  modport master (
    output paddr_o, pprot_o, pwrite_o, pwdata_o, pstrb_o, psel_o, penable_o,
    input  pready_i, pslverr_i, prdata_i
  );

  modport slave (
    input  paddr_o, pprot_o, pwrite_o, pwdata_o, pstrb_o, psel_o, penable_o,
    output pready_i, pslverr_i, prdata_i
  );
endinterface

// File: rtl/apb4_master.sv
// APB4 master: one outstanding transfer, valid/ready command in and response out, fully registered APB outputs.
// Optional macro APB4_MST_TIMEOUT_EN aborts an ACCESS phase after TIMEOUT_CYCLES cycles without pready_i.
module apb4_master #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic                    req_write_i,
  input  logic [ADDR_WIDTH-1:0]   req_addr_i,
  input  logic [DATA_WIDTH-1:0]   req_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] req_strb_i,
  input  logic [2:0]              req_prot_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
  output logic                    rsp_err_o,
  apb4_master_if.master           apb
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  generate
    if (!(DATA_WIDTH == 8 || DATA_WIDTH == 16 || DATA_WIDTH == 32)) begin : g_bad_data_width
      $error("apb4_master: DATA_WIDTH must be 8, 16 or 32");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("apb4_master: TIMEOUT_CYCLES must be at least 1");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_e;

  state_e                  state_q,     state_d;
  logic [ADDR_WIDTH-1:0]   paddr_q,     paddr_d;
  logic [2:0]              pprot_q,     pprot_d;
  logic                    pwrite_q,    pwrite_d;
  logic [DATA_WIDTH-1:0]   pwdata_q,    pwdata_d;
  logic [STRB_WIDTH-1:0]   pstrb_q,     pstrb_d;
  logic                    psel_q,      psel_d;
  logic                    penable_q,   penable_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                    rsp_err_q,   rsp_err_d;

`ifdef APB4_MST_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  // Gated by rst_i so no command is taken while reset is held, yet it rises as soon as reset drops.
  assign req_ready_o = (state_q == IDLE) && !rst_i;

  always_comb begin
    state_d     = state_q;
    paddr_d     = paddr_q;
    pprot_d     = pprot_q;
    pwrite_d    = pwrite_q;
    pwdata_d    = pwdata_q;
    pstrb_d     = pstrb_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
`ifdef APB4_MST_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif

    case (state_q)
      IDLE: begin
        if (req_valid_i && req_ready_o) begin
          state_d  = SETUP;
          paddr_d  = req_addr_i;
          pprot_d  = req_prot_i;
          pwrite_d = req_write_i;
          pwdata_d = req_wdata_i;
          pstrb_d  = req_write_i ? req_strb_i : '0;
          psel_d   = 1'b1;
        end
      end

      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
`ifdef APB4_MST_TIMEOUT_EN
        cnt_d     = '0;
`endif
      end

      ACCESS: begin
        // A completer answer on the last counted cycle wins over the timeout.
        if (apb.pready_i) begin
          state_d     = RESP;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = apb.pslverr_i;
          rsp_rdata_d = pwrite_q ? '0 : apb.prdata_i;
        end
`ifdef APB4_MST_TIMEOUT_EN
        else if (cnt_q == CNT_LAST) begin
          state_d     = RESP;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end

      RESP: begin
        if (rsp_ready_i) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
        end
      end

      default: begin
        state_d   = IDLE;
        psel_d    = 1'b0;
        penable_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      paddr_q     <= '0;
      pprot_q     <= '0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
      pstrb_q     <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
`ifdef APB4_MST_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      paddr_q     <= paddr_d;
      pprot_q     <= pprot_d;
      pwrite_q    <= pwrite_d;
      pwdata_q    <= pwdata_d;
      pstrb_q     <= pstrb_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
`ifdef APB4_MST_TIMEOUT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign apb.paddr_o   = paddr_q;
  assign apb.pprot_o   = pprot_q;
  assign apb.pwrite_o  = pwrite_q;
  assign apb.pwdata_o  = pwdata_q;
  assign apb.pstrb_o   = pstrb_q;
  assign apb.psel_o    = psel_q;
  assign apb.penable_o = penable_q;

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;

endmodule

// File: doc/apb4_master.md
APB4_MASTER -- requirements
Module: apb4_master

Interface
REQ-001 Parameter ADDR_WIDTH, 32, width of request address and paddr_o.
REQ-002 Parameter DATA_WIDTH, 32, width of data buses; SHALL be 8, 16 or 32.
REQ-003 Parameter TIMEOUT_CYCLES, 256, max ACCESS cycles before abort; only used with APB4_MST_TIMEOUT_EN.
REQ-004 clk_i  input  1  single clock; all flops rising-edge.
REQ-005 rst_i  input  1  reset, asynchronous, active-high.
REQ-006 req_valid_i  input  1  command valid.
REQ-007 req_ready_o  output  1  command accepted when high with req_valid_i.
REQ-008 req_write_i  input  1  1 = write, 0 = read.
REQ-009 req_addr_i  input  ADDR_WIDTH  target address.
REQ-010 req_wdata_i  input  DATA_WIDTH  write data.
REQ-011 req_strb_i  input  DATA_WIDTH/8  write byte strobes.
REQ-012 req_prot_i  input  3  protection attributes.
REQ-013 rsp_valid_o  output  1  response valid.
REQ-014 rsp_ready_i  input  1  response consumed when high with rsp_valid_o.
REQ-015 rsp_rdata_o  output  DATA_WIDTH  read data; 0 for writes.
REQ-016 rsp_err_o  output  1  slave error or timeout.
REQ-017 paddr_o, pprot_o, pwrite_o, pwdata_o, pstrb_o  output  ADDR_WIDTH/3/1/DATA_WIDTH/DATA_WIDTH/8  APB4 request fields.
REQ-018 psel_o, penable_o  output  1  APB4 select and enable.
REQ-019 pready_i, pslverr_i  input  1  APB4 ready and error; prdata_i  input  DATA_WIDTH  read data.

Function
REQ-020 FSM states IDLE, SETUP, ACCESS, RESP; req_ready_o = 1 only in IDLE.
REQ-021 IDLE: on req_valid_i&&req_ready_o, register all request fields, go SETUP next cycle.
REQ-022 SETUP: psel_o=1, penable_o=0, exactly one cycle, then ACCESS.
REQ-023 ACCESS: psel_o=1, penable_o=1; hold until pready_i=1, then capture prdata_i (reads only) and pslverr_i, go RESP.
REQ-024 paddr_o, pprot_o, pwrite_o, pwdata_o, pstrb_o SHALL be stable from SETUP through last ACCESS cycle.
REQ-025 pstrb_o SHALL be 0 for reads regardless of req_strb_i.
REQ-026 In IDLE and RESP psel_o=0, penable_o=0; request fields hold last value.
REQ-027 RESP: rsp_valid_o=1 with rsp_rdata_o/rsp_err_o stable until rsp_ready_i=1, then IDLE.
REQ-028 Minimum latency: accept at cycle T, psel_o at T+1, penable_o at T+2, rsp_valid_o at T+3 when pready_i=1 at T+2.
REQ-029 One outstanding transfer; next request accepted no earlier than cycle after response handshake.
REQ-030 pready_i, pslverr_i, prdata_i ignored outside ACCESS.

Reset
REQ-031 rst_i=1 SHALL immediately force IDLE, psel_o=penable_o=rsp_valid_o=0, req_ready_o=0 while asserted, all data/address outputs 0.
REQ-032 Reset mid-transfer SHALL discard the transfer; no response is produced after reset release.
REQ-033 req_ready_o SHALL be 1 in the first cycle after rst_i deasserts.

Configuration
REQ-034 Macro APB4_MST_TIMEOUT_EN defined: counter of ACCESS cycles; at TIMEOUT_CYCLES cycles without pready_i, drop psel_o/penable_o, go RESP with rsp_err_o=1, rsp_rdata_o=0.
REQ-035 Counter clears on entry to ACCESS; pready_i on the final counted cycle completes normally (no timeout).
REQ-036 Macro undefined: no counter logic; ACCESS waits indefinitely; TIMEOUT_CYCLES unused.

Verification
REQ-037 Write addr 0x4, data 0xDEADBEEF, strb 0xF, pready_i=1 immediately -> psel T+1, penable T+2, pwdata 0xDEADBEEF, rsp_valid T+3, err 0.
REQ-038 Read addr 0x8, pready_i low 3 ACCESS cycles, prdata_i 0x12345678 -> signals stable 4 ACCESS cycles, pstrb 0, rsp_rdata 0x12345678.
REQ-039 Read with pslverr_i=1 at pready -> rsp_err_o=1; rsp_ready_i low 5 cycles -> rsp_valid/rsp_err held, req_ready_o 0 throughout.
REQ-040 rst_i pulsed during ACCESS -> psel/penable 0 same cycle, no rsp_valid afterward, req_ready_o 1 after release.
REQ-041 With APB4_MST_TIMEOUT_EN, TIMEOUT_CYCLES=4, pready_i held 0 -> penable drops after 4 ACCESS cycles, rsp_err_o=1, rsp_rdata_o=0.
REQ-042 Back-to-back requests with rsp_ready_i=1 -> second psel_o no earlier than cycle after first response handshake.
